// File: rtl/branch_sequencer_if.sv
// Bundles the request, instruction-byte FIFO and redirect/CX-writeback signals
// of branch_sequencer. The slave modport is the sequencer; master is its environment.
interface branch_sequencer_if;
    logic        start;
    logic [7:0]  opcode;
    logic [15:0] flags;
    logic [15:0] cx;
    logic [15:0] ip;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en;
    logic        busy;
    logic        done;
    logic        invalid;
    logic        jump;
    logic [15:0] jump_target;
    logic        cx_wr_en;
    logic [15:0] cx_wr_val;

    modport master (
        output start, opcode, flags, cx, ip, fifo_empty, fifo_rd_data,
        input  fifo_rd_en, busy, done, invalid, jump, jump_target, cx_wr_en, cx_wr_val
    );

    modport slave (
        input  start, opcode, flags, cx, ip, fifo_empty, fifo_rd_data,
        output fifo_rd_en, busy, done, invalid, jump, jump_target, cx_wr_en, cx_wr_val
    );
endinterface

// File: rtl/branch_sequencer.sv
// Short conditional branch sequencer: Jcc 0x70-0x7F, plus LOOPNE/LOOPE/LOOP/JCXZ
// (0xE0-0xE3) when BRANCH_SEQ_LOOP_EN is defined.
module branch_sequencer (
    input  logic              clk,
    input  logic              reset_n,
    branch_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FETCH, RESOLVE} state_t;

    typedef struct packed {
        logic ovf;
        logic sf;
        logic zf;
        logic pf;
        logic cf;
    } flags_t;

    state_t      state;
    flags_t      flags_q;
    logic [3:0]  cc_q;
    logic [15:0] ip_q;

    logic        busy_q;
    logic        done_q;
    logic        invalid_q;
    logic        jump_q;
    logic [15:0] jump_target_q;
    logic        cx_wr_en_q;
    logic [15:0] cx_wr_val_q;

    logic        is_jcc;
    logic        supported;
    logic        taken;
    logic        pop;
    logic [15:0] target;

    assign is_jcc = (bus.opcode[7:4] == 4'h7);

`ifdef BRANCH_SEQ_LOOP_EN
    logic        loop_q;
    logic [15:0] cx_q;
    logic        is_loop;
    logic [15:0] cx_dec;
    logic        cx_write;

    assign is_loop   = (bus.opcode[7:2] == 6'b111000);
    assign supported = is_jcc | is_loop;
    assign cx_dec    = cx_q - 16'd1;
    // JCXZ (low bits 11) tests CX but never writes it back.
    assign cx_write  = loop_q && (cc_q[1:0] != 2'b11);
`else
    assign supported = is_jcc;
`endif

    function automatic logic cond_met(input logic [3:0] cc, input flags_t f);
        logic base;
        base = 1'b0;
        case (cc[3:1])
            3'd0: base = f.ovf;
            3'd1: base = f.cf;
            3'd2: base = f.zf;
            3'd3: base = f.cf | f.zf;
            3'd4: base = f.sf;
            3'd5: base = f.pf;
            3'd6: base = f.sf ^ f.ovf;
            3'd7: base = (f.sf ^ f.ovf) | f.zf;
            default: base = 1'b0;
        endcase
        return base ^ cc[0];
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        taken = cond_met(cc_q, flags_q);
`ifdef BRANCH_SEQ_LOOP_EN
        if (loop_q) begin
            case (cc_q[1:0])
                2'b00:   taken = (cx_dec != 16'd0) && !flags_q.zf;
                2'b01:   taken = (cx_dec != 16'd0) && flags_q.zf;
                2'b10:   taken = (cx_dec != 16'd0);
                default: taken = (cx_q == 16'd0);
            endcase
        end
`endif
    end

    // Outcome is resolved in the pop cycle so the registered pulses land one cycle later.
    assign target = ip_q + 16'd1 + {{8{bus.fifo_rd_data[7]}}, bus.fifo_rd_data};
    assign pop    = (state == FETCH) && !bus.fifo_empty;

    assign bus.fifo_rd_en  = pop;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.invalid     = invalid_q;
    assign bus.jump        = jump_q;
    assign bus.jump_target = jump_target_q;
    assign bus.cx_wr_en    = cx_wr_en_q;
    assign bus.cx_wr_val   = cx_wr_val_q;

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            flags_q       <= '0;
            cc_q          <= '0;
            ip_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            invalid_q     <= 1'b0;
            jump_q        <= 1'b0;
            jump_target_q <= '0;
            cx_wr_en_q    <= 1'b0;
            cx_wr_val_q   <= '0;
`ifdef BRANCH_SEQ_LOOP_EN
            loop_q        <= 1'b0;
            cx_q          <= '0;
`endif
        end else begin
            done_q        <= 1'b0;
            invalid_q     <= 1'b0;
            jump_q        <= 1'b0;
            jump_target_q <= '0;
            cx_wr_en_q    <= 1'b0;
            cx_wr_val_q   <= '0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (supported) begin
                            state   <= FETCH;
                            busy_q  <= 1'b1;
                            cc_q    <= bus.opcode[3:0];
                            ip_q    <= bus.ip;
                            flags_q <= '{ovf: bus.flags[11], sf: bus.flags[7],
                                         zf: bus.flags[6], pf: bus.flags[2],
                                         cf: bus.flags[0]};
`ifdef BRANCH_SEQ_LOOP_EN
                            loop_q  <= is_loop;
                            cx_q    <= bus.cx;
`endif
                        end else begin
                            done_q    <= 1'b1;
                            invalid_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (pop) begin
                        state         <= RESOLVE;
                        done_q        <= 1'b1;
                        jump_q        <= taken;
                        jump_target_q <= taken ? target : 16'd0;
`ifdef BRANCH_SEQ_LOOP_EN
                        cx_wr_en_q    <= cx_write;
                        cx_wr_val_q   <= cx_write ? cx_dec : 16'd0;
`endif
                    end
                end
                RESOLVE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed, table-driven bench for branch_sequencer; expectations track BRANCH_SEQ_LOOP_EN.
module tb_branch_sequencer;

`ifdef BRANCH_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    branch_sequencer_if b ();

    branch_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] flags;
        logic [15:0] cx;
        logic [15:0] ip;
        logic [7:0]  disp;
        logic        inv;
        logic        jmp;
        logic [15:0] tgt;
        logic        cxen;
        logic [15:0] cxval;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Loop-form opcodes are unsupported when the loop feature is compiled out.
    function automatic vec_t mk(input logic [7:0] op, input logic [15:0] flags,
                                input logic [15:0] cx, input logic [15:0] ip,
                                input logic [7:0] disp, input logic inv, input logic jmp,
                                input logic [15:0] tgt, input logic cxen,
                                input logic [15:0] cxval);
        vec_t v;
        v = '{op, flags, cx, ip, disp, inv, jmp, tgt, cxen, cxval};
        if (!LOOP_EN && (op[7:2] == 6'b111000)) begin
            v.inv = 1'b1; v.jmp = 1'b0; v.tgt = 16'h0; v.cxen = 1'b0; v.cxval = 16'h0;
        end
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"},   32'(b.busy), 32'h0);
        check({tag, ".done"},   32'(b.done), 32'h0);
        check({tag, ".rd_en"},  32'(b.fifo_rd_en), 32'h0);
        check({tag, ".jump"},   32'(b.jump), 32'h0);
        check({tag, ".target"}, 32'(b.jump_target), 32'h0);
        check({tag, ".cx_en"},  32'(b.cx_wr_en), 32'h0);
        check({tag, ".cx_val"}, 32'(b.cx_wr_val), 32'h0);
        check({tag, ".inv"},    32'(b.invalid), 32'h0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        b.start = 1'b1; b.opcode = v.op; b.flags = v.flags; b.cx = v.cx; b.ip = v.ip;
        b.fifo_empty = 1'b1; b.fifo_rd_data = 8'h00;
        @(negedge clk);
        b.start = 1'b0; b.opcode = 8'h00; b.flags = ~v.flags; b.cx = 16'hAAAA; b.ip = 16'h5555;
        b.fifo_empty = 1'b0; b.fifo_rd_data = v.disp;
        #1;
        if (v.inv) begin
            check({tag, ".t1.done"},  32'(b.done), 32'h1);
            check({tag, ".t1.inv"},   32'(b.invalid), 32'h1);
            check({tag, ".t1.rd_en"}, 32'(b.fifo_rd_en), 32'h0);
            check({tag, ".t1.jump"},  32'(b.jump), 32'h0);
            check({tag, ".t1.cx_en"}, 32'(b.cx_wr_en), 32'h0);
            step();
            b.fifo_empty = 1'b1;
            check({tag, ".t2.done"},  32'(b.done), 32'h0);
            check({tag, ".t2.inv"},   32'(b.invalid), 32'h0);
            check({tag, ".t2.rd_en"}, 32'(b.fifo_rd_en), 32'h0);
        end else begin
            check({tag, ".t1.rd_en"}, 32'(b.fifo_rd_en), 32'h1);
            check({tag, ".t1.busy"},  32'(b.busy), 32'h1);
            check({tag, ".t1.done"},  32'(b.done), 32'h0);
            @(negedge clk);
            b.fifo_empty = 1'b1; b.fifo_rd_data = 8'h00;
            #1;
            check({tag, ".t2.done"},   32'(b.done), 32'h1);
            check({tag, ".t2.inv"},    32'(b.invalid), 32'h0);
            check({tag, ".t2.busy"},   32'(b.busy), 32'h1);
            check({tag, ".t2.rd_en"},  32'(b.fifo_rd_en), 32'h0);
            check({tag, ".t2.jump"},   32'(b.jump), 32'(v.jmp));
            check({tag, ".t2.target"}, 32'(b.jump_target), 32'(v.tgt));
            check({tag, ".t2.cx_en"},  32'(b.cx_wr_en), 32'(v.cxen));
            check({tag, ".t2.cx_val"}, 32'(b.cx_wr_val), 32'(v.cxval));
            step();
            check_idle_outputs({tag, ".t3"});
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        b.start = 1'b0; b.opcode = 8'h00; b.flags = 16'h0; b.cx = 16'h0; b.ip = 16'h0;
        b.fifo_empty = 1'b1; b.fifo_rd_data = 8'h00;

        //            op     flags    cx       ip       disp   inv  jmp  tgt      cxen cxval
        vecs.push_back(mk(8'h74, 16'h0040, 16'h0000, 16'h0100, 8'h10, 0, 1, 16'h0111, 0, 16'h0000));
        vecs.push_back(mk(8'h7C, 16'h0880, 16'h0000, 16'h0200, 8'hFE, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(8'h70, 16'h0800, 16'h0000, 16'h0010, 8'h80, 0, 1, 16'hFF91, 0, 16'h0000));
        vecs.push_back(mk(8'h73, 16'h0001, 16'h0000, 16'h0010, 8'h04, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(8'h76, 16'h0040, 16'h0000, 16'hFFFF, 8'h00, 0, 1, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(8'h7A, 16'h0004, 16'h0000, 16'h1234, 8'h05, 0, 1, 16'h123A, 0, 16'h0000));
        vecs.push_back(mk(8'h7F, 16'h0000, 16'h0000, 16'h8000, 8'h7F, 0, 1, 16'h8080, 0, 16'h0000));
        vecs.push_back(mk(8'h79, 16'h0080, 16'h0000, 16'h4000, 8'h01, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(8'h90, 16'h0000, 16'h0000, 16'h0100, 8'h10, 1, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(8'h6F, 16'h0000, 16'h0000, 16'h0100, 8'h10, 1, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(8'hE2, 16'h0000, 16'h0001, 16'h0050, 8'hF0, 0, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(8'hE2, 16'h0000, 16'h0000, 16'h0005, 8'hF0, 0, 1, 16'hFFF6, 1, 16'hFFFF));
        vecs.push_back(mk(8'hE1, 16'h0040, 16'h0005, 16'h0100, 8'h02, 0, 1, 16'h0103, 1, 16'h0004));
        vecs.push_back(mk(8'hE0, 16'h0040, 16'h0005, 16'h0100, 8'h02, 0, 0, 16'h0000, 1, 16'h0004));
        vecs.push_back(mk(8'hE3, 16'h0000, 16'h0001, 16'h1000, 8'h7F, 0, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(8'hE4, 16'h0000, 16'h0000, 16'h1000, 8'h7F, 1, 0, 16'h0000, 0, 16'h0000));

        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d_op%02h", i, vecs[i].op));
        end

        // JNE with FIFO empty three cycles; a second start while busy must be ignored.
        @(negedge clk);
        b.start = 1'b1; b.opcode = 8'h75; b.flags = 16'h0000; b.ip = 16'h0300; b.cx = 16'h0;
        b.fifo_empty = 1'b1;
        step();
        b.start = 1'b0;
        check("stall.t1.busy",  32'(b.busy), 32'h1);
        check("stall.t1.rd_en", 32'(b.fifo_rd_en), 32'h0);
        step();
        check("stall.t2.rd_en", 32'(b.fifo_rd_en), 32'h0);
        check("stall.t2.done",  32'(b.done), 32'h0);
        @(negedge clk);
        b.start = 1'b1; b.opcode = 8'h74; b.flags = 16'h0040; b.ip = 16'h7000;
        #1;
        check("stall.t3.rd_en", 32'(b.fifo_rd_en), 32'h0);
        check("stall.t3.busy",  32'(b.busy), 32'h1);
        @(negedge clk);
        b.start = 1'b0; b.fifo_empty = 1'b0; b.fifo_rd_data = 8'h20;
        #1;
        check("stall.t4.rd_en", 32'(b.fifo_rd_en), 32'h1);
        check("stall.t4.done",  32'(b.done), 32'h0);
        @(negedge clk);
        b.fifo_empty = 1'b1;
        #1;
        check("stall.t5.done",   32'(b.done), 32'h1);
        check("stall.t5.jump",   32'(b.jump), 32'h1);
        check("stall.t5.target", 32'(b.jump_target), 32'h0321);
        check("stall.t5.busy",   32'(b.busy), 32'h1);
        step();
        check_idle_outputs("stall.t6");
        step();
        check_idle_outputs("stall.t7");

        // start in the done cycle (T+2) is ignored even with FIFO data ready.
        @(negedge clk);
        b.start = 1'b1; b.opcode = 8'h74; b.flags = 16'h0040; b.ip = 16'h0100;
        b.fifo_empty = 1'b1;
        @(negedge clk);
        b.start = 1'b0; b.fifo_empty = 1'b0; b.fifo_rd_data = 8'h10;
        @(negedge clk);
        b.start = 1'b1; b.opcode = 8'h75; b.flags = 16'h0000;
        #1;
        check("late.t2.done",   32'(b.done), 32'h1);
        check("late.t2.target", 32'(b.jump_target), 32'h0111);
        @(negedge clk);
        b.start = 1'b0;
        #1;
        check("late.t3.busy",  32'(b.busy), 32'h0);
        check("late.t3.rd_en", 32'(b.fifo_rd_en), 32'h0);
        step();
        check_idle_outputs("late.t4");
        b.fifo_empty = 1'b1;

        // Reset while in FETCH aborts the branch.
        @(negedge clk);
        b.start = 1'b1; b.opcode = 8'h74; b.flags = 16'h0040; b.ip = 16'h0100;
        b.fifo_empty = 1'b1;
        step();
        b.start = 1'b0;
        check("abort.fetch.busy", 32'(b.busy), 32'h1);
        #1;
        reset_n = 1'b0;
        b.fifo_empty = 1'b0; b.fifo_rd_data = 8'h10;
        #1;
        check_idle_outputs("abort.in_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_idle_outputs("abort.after1");
        step();
        check_idle_outputs("abort.after2");
        b.fifo_empty = 1'b1;

        apply(mk(8'hE3, 16'h0000, 16'h0000, 16'h1000, 8'h7F, 0, 1, 16'h1080, 0, 16'h0000),
              "jcxz_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
